hazard_sequencer: RTL
=====================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 The block SHALL have the following parameters:
- RW, 5: register address width.
- LOAD_LAT, 1: load-use stall cycles, 1..4.
- FLUSH_CYC, 1: flush cycles per redirect, 1..3.

REQ-002 The block SHALL have the following ports:
- CLK  in  1  sole clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- de_rs1, de_rs2  in  RW  DE-stage source addresses.
- de_rs1_used, de_rs2_used  in  1  DE sources read.
- ex_rs1, ex_rs2  in  RW  EX-stage source addresses.
- ex_rs1_used, ex_rs2_used  in  1  EX sources read.
- ex_rd, ex_memread  in  RW/1  EX destination; EX is a load.
- mem_rd, mem_rs2  in  RW  MEM destination; store-data source.
- mem_regwrite, mem_memread, mem_memwrite  in  1  MEM controls.
- wb_rd, wb_regwrite, wb_memread  in  RW/1/1  WB destination and controls.
- redirect  in  1  EX resolved taken branch/jal/jalr.
- dmem_ready  in  1  data memory completes the MEM access this cycle.
- fsel1, fsel2  out  2  EX operand forward select: 00 regfile, 01 WB, 10 MEM.
- store_fwd  out  1  forward WB load data to MEM store data.
- stall_fd  out  1  hold PC, IF/DE register.
- bubble_ex  out  1  load NOP into DE/EX.
- flush  out  1  squash IF/DE and DE/EX.
- freeze  out  1  hold every pipeline register.
- state  out  2  FSM state: 00 RUN, 01 LU_STALL, 10 FLUSH, 11 MEM_WAIT.

Function
REQ-003 fsel1 SHALL be 10 if mem_regwrite, mem_rd!=0, mem_rd==ex_rs1 and ex_rs1_used; else 01 if the same holds for wb_rd/wb_regwrite; else 00.
REQ-004 fsel2 SHALL be computed like fsel1, from ex_rs2 and ex_rs2_used, independently of fsel1.
REQ-005 A load-use hazard (lu) SHALL be ex_memread && ex_rd!=0 && ((ex_rd==de_rs1 && de_rs1_used) || (ex_rd==de_rs2 && de_rs2_used)).
REQ-006 A memory wait (mw) SHALL be (mem_memread || mem_memwrite) && !dmem_ready.
REQ-007 In every state, event priority SHALL be mw > redirect > lu.
REQ-008 In RUN with mw, freeze SHALL be 1 combinationally and the next state SHALL be MEM_WAIT.
REQ-009 In MEM_WAIT, freeze SHALL be 1 while dmem_ready=0; on dmem_ready=1, freeze SHALL be 0 that cycle and the next state SHALL be RUN.
REQ-010 In RUN with redirect and no mw, flush SHALL be 1 that cycle.
REQ-011 For that redirect, the flush counter SHALL load FLUSH_CYC-1 and the FSM SHALL enter FLUSH if the loaded value is nonzero, else stay in RUN.
REQ-012 In FLUSH, flush SHALL be 1 and the counter SHALL decrement each cycle, returning to RUN when it reaches 0.
REQ-013 A redirect arriving in FLUSH SHALL reload the flush counter to FLUSH_CYC-1.
REQ-014 In RUN with lu and no mw or redirect, stall_fd and bubble_ex SHALL be 1 that cycle.
REQ-015 For that lu, the stall counter SHALL load LOAD_LAT-1 and the FSM SHALL enter LU_STALL if the loaded value is nonzero.
REQ-016 In LU_STALL, stall_fd and bubble_ex SHALL be 1 and the counter SHALL decrement, returning to RUN at 0.
REQ-017 A redirect arriving in LU_STALL SHALL abort the stall and be handled as in REQ-010/REQ-011.
REQ-018 While freeze=1, the counters SHALL hold and flush, stall_fd and bubble_ex SHALL be 0.
REQ-019 Counter width SHALL be $clog2(max(LOAD_LAT,FLUSH_CYC))+1 bits, and counters SHALL never wrap below 0.

Reset
REQ-020 With RST=1 at a clock edge, the FSM SHALL go to RUN and both counters SHALL clear to 0.
REQ-021 While RST=1, all outputs SHALL be 0, including fsel1/fsel2=00 and state=00.
REQ-022 A reset in any state SHALL abort the operation in progress, with no residual stall or flush cycle afterwards.

Configuration
REQ-023 With macro HAZARD_STORE_FWD_EN defined, store_fwd SHALL be 1 when mem_memwrite && wb_memread && wb_rd!=0 && wb_rd==mem_rs2.
REQ-024 Without HAZARD_STORE_FWD_EN, the store_fwd port SHALL remain present and be tied to 0.

Verification
REQ-025 Forwarding: mem_rd=5, wb_rd=5, both regwrite, ex_rs1=ex_rs2=5, both used -> fsel1=fsel2=10; with mem_regwrite=0 -> fsel1=fsel2=01.
REQ-026 Load-use: LOAD_LAT=3, ex_memread=1, ex_rd=7, de_rs2=7 used -> stall_fd=bubble_ex=1 for exactly 3 cycles; state sequence 00,01,01,00.
REQ-027 Redirect: FLUSH_CYC=2, redirect pulsed 1 cycle -> flush=1 for 2 cycles; with lu also high, flush wins and bubble_ex=0.
REQ-028 Memory wait: mem_memread=1, dmem_ready low 4 cycles -> freeze=1 for 4 cycles with redirect held high and flush=0; redirect is serviced the cycle dmem_ready=1.
REQ-029 Reset: RST asserted in the second cycle of LU_STALL (LOAD_LAT=4) -> all outputs 0 next cycle, state=00, no further stall.
REQ-030 Store forward: mem_memwrite=1, mem_rs2=9, wb_memread=1, wb_rd=9 -> store_fwd=1 with the macro defined, 0 without it.

Source files
------------

// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline hazard control for a 5-stage in-order core: EX operand
//   forwarding selects, load-use stall, redirect flush and data-memory
//   wait freeze, sequenced by a small FSM with two down-counters.
//
// Parameters
//   RW        register address width
//   LOAD_LAT  load-use stall cycles (1..4)
//   FLUSH_CYC flush cycles per redirect (1..3)
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   de_rs1/2, de_rs1/2_used   DE-stage sources
//   ex_rs1/2, ex_rs1/2_used   EX-stage sources
//   ex_rd, ex_memread         EX destination, EX is a load
//   mem_rd, mem_rs2           MEM destination, store-data source
//   mem_regwrite/memread/memwrite  MEM controls
//   wb_rd, wb_regwrite, wb_memread WB destination and controls
//   redirect                  EX resolved taken branch/jal/jalr
//   dmem_ready                data memory completes MEM access this cycle
//   fsel1, fsel2              EX operand select: 00 regfile, 01 WB, 10 MEM
//   store_fwd                 forward WB load data to MEM store data
//   stall_fd, bubble_ex       hold PC + IF/DE, insert NOP into DE/EX
//   flush                     squash IF/DE and DE/EX
//   freeze                    hold every pipeline register
//   state                     00 RUN, 01 LU_STALL, 10 FLUSH, 11 MEM_WAIT
//
// Build option
//   HAZARD_STORE_FWD_EN  enables WB-load -> MEM-store data forwarding;
//                        without it store_fwd is tied to 0.
module hazard_sequencer #(
  parameter int RW        = 5,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [RW-1:0] de_rs1,
  input  logic [RW-1:0] de_rs2,
  input  logic          de_rs1_used,
  input  logic          de_rs2_used,
  input  logic [RW-1:0] ex_rs1,
  input  logic [RW-1:0] ex_rs2,
  input  logic          ex_rs1_used,
  input  logic          ex_rs2_used,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_memread,
  input  logic [RW-1:0] mem_rd,
  input  logic [RW-1:0] mem_rs2,
  input  logic          mem_regwrite,
  input  logic          mem_memread,
  input  logic          mem_memwrite,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_regwrite,
  input  logic          wb_memread,
  input  logic          redirect,
  input  logic          dmem_ready,
  output logic [1:0]    fsel1,
  output logic [1:0]    fsel2,
  output logic          store_fwd,
  output logic          stall_fd,
  output logic          bubble_ex,
  output logic          flush,
  output logic          freeze,
  output logic [1:0]    state
);

  localparam int CNT_MAX = (LOAD_LAT > FLUSH_CYC) ? LOAD_LAT : FLUSH_CYC;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] LU_LOAD = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] FL_LOAD = CW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_LU    = 2'b01,
    ST_FLUSH = 2'b10,
    ST_MEMW  = 2'b11
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] scnt_reg, scnt_next;
  logic [CW-1:0] fcnt_reg, fcnt_next;

  // ---------------- forwarding (one identical unit per operand) ----------
  logic [RW-1:0] ex_rs   [2];
  logic          ex_used [2];
  logic [1:0]    fsel_raw[2];

  assign ex_rs[0]   = ex_rs1;
  assign ex_rs[1]   = ex_rs2;
  assign ex_used[0] = ex_rs1_used;
  assign ex_used[1] = ex_rs2_used;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      // MEM is younger than WB, so it wins when both match.
      always_comb begin
        fsel_raw[gi] = 2'b00;
        if (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs[gi] && ex_used[gi])
          fsel_raw[gi] = 2'b10;
        else if (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs[gi] && ex_used[gi])
          fsel_raw[gi] = 2'b01;
      end
    end
  endgenerate

  // ---------------- event decode ----------------------------------------
  logic lu, mw, hold_c, redir_c, lu_c;

  assign lu = ex_memread && (ex_rd != '0) &&
              ((ex_rd == de_rs1 && de_rs1_used) || (ex_rd == de_rs2 && de_rs2_used));
  assign mw = (mem_memread || mem_memwrite) && !dmem_ready;

  // MEM_WAIT keeps the pipeline frozen until the memory answers, even if
  // the MEM controls drop meanwhile; elsewhere a fresh mw freezes.
  assign hold_c  = (state_reg == ST_MEMW) ? !dmem_ready : mw;
  assign redir_c = !hold_c && redirect;
  // A new load-use stall can only start from RUN (or a completing MEM_WAIT,
  // which behaves as RUN on its release cycle).
  assign lu_c    = !hold_c && !redirect && lu &&
                   (state_reg == ST_RUN || state_reg == ST_MEMW);

  // ---------------- state register --------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_RUN;
      scnt_reg  <= '0;
      fcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      scnt_reg  <= scnt_next;
      fcnt_reg  <= fcnt_next;
    end
  end

  // ---------------- next-state logic ------------------------------------
  always_comb begin
    state_next = state_reg;
    scnt_next  = scnt_reg;
    fcnt_next  = fcnt_reg;
    if (hold_c) begin
      // Counters and any stall/flush in progress are held across the freeze.
      if (state_reg == ST_RUN)
        state_next = ST_MEMW;
    end else if (redir_c) begin
      // A redirect overrides (or restarts) whatever is in progress.
      scnt_next  = '0;
      fcnt_next  = FL_LOAD;
      state_next = (FL_LOAD != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      unique case (state_reg)
        ST_RUN, ST_MEMW: begin
          state_next = ST_RUN;
          if (lu_c) begin
            scnt_next  = LU_LOAD;
            state_next = (LU_LOAD != '0) ? ST_LU : ST_RUN;
          end
        end
        ST_LU: begin
          scnt_next  = (scnt_reg == '0) ? '0 : scnt_reg - 1'b1;
          if (scnt_next == '0)
            state_next = ST_RUN;
        end
        ST_FLUSH: begin
          fcnt_next  = (fcnt_reg == '0) ? '0 : fcnt_reg - 1'b1;
          if (fcnt_next == '0)
            state_next = ST_RUN;
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  // ---------------- outputs ---------------------------------------------
  logic sf_raw;

`ifdef HAZARD_STORE_FWD_EN
  assign sf_raw = mem_memwrite && wb_memread && (wb_rd != '0) && (wb_rd == mem_rs2);
`else
  assign sf_raw = 1'b0;
  logic unused_sf;
  assign unused_sf = &{1'b0, mem_rs2, wb_memread};
`endif

  // Everything is forced low while reset is asserted.
  always_comb begin
    fsel1     = 2'b00;
    fsel2     = 2'b00;
    store_fwd = 1'b0;
    stall_fd  = 1'b0;
    bubble_ex = 1'b0;
    flush     = 1'b0;
    freeze    = 1'b0;
    state     = 2'b00;
    if (!RST) begin
      fsel1     = fsel_raw[0];
      fsel2     = fsel_raw[1];
      store_fwd = sf_raw;
      freeze    = hold_c;
      flush     = redir_c || (!hold_c && state_reg == ST_FLUSH);
      stall_fd  = lu_c || (!hold_c && !redirect && state_reg == ST_LU);
      bubble_ex = stall_fd;
      state     = state_reg;
    end
  end

endmodule
